// File: rtl/monopix2_ro_emulator.sv
// Chip-side MONOPIX2 column readout model: queues hit words and answers the
// receiver's FREEZE/READ handshake with a token and an MSB-first serial stream.
module monopix2_ro_emulator #(
    parameter int DATA_WIDTH = 27,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  HIT_WR,
    input  logic [DATA_WIDTH-1:0] HIT_DATA,
    output logic                  HIT_FULL,
    input  logic                  FREEZE,
    input  logic                  READ,
    output logic                  TOKOUT,
    output logic                  DATAOUT,
    output logic [7:0]            LOST_CNT,
    output logic [7:0]            READ_ERR_CNT
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int BW    = $clog2(DATA_WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_d;
    logic [CW-1:0]           vis_cnt_q;
    logic [DATA_WIDTH-1:0]   shreg_q;
    logic [BW-1:0]           bcnt_q;
    logic                    freeze_q;
    logic                    read_q;
    logic                    tok_q;
    logic                    full_q;
    logic [7:0]              lost_q;
    logic [7:0]              err_q;

    logic full_s;
    logic wr_ok_s;
    logic read_rise_s;
    logic freeze_rise_s;
    logic accept_s;

    assign full_s        = (count_q == CW'(DEPTH));
    assign wr_ok_s       = HIT_WR & ~full_s;
    assign read_rise_s   = READ & ~read_q;
    assign freeze_rise_s = FREEZE & ~freeze_q;
    assign accept_s      = read_rise_s && (state_q == IDLE) && freeze_q && (vis_cnt_q != CW'(0));

    // FIFO occupancy after this edge: a push and a pop in the same cycle cancel.
    always_comb begin
        count_d = count_q;
        if (wr_ok_s && !accept_s) begin
            count_d = count_q + CW'(1);
        end else if (!wr_ok_s && accept_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Hit storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (wr_ok_s && !RST) begin
            mem_q[wr_ptr_q] <= HIT_DATA;
        end
    end

    // Handshake edge detect, FIFO bookkeeping, counters and the serializer FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            vis_cnt_q <= '0;
            shreg_q   <= '0;
            bcnt_q    <= '0;
            freeze_q  <= 1'b0;
            read_q    <= 1'b0;
            tok_q     <= 1'b0;
            full_q    <= 1'b0;
            lost_q    <= 8'd0;
            err_q     <= 8'd0;
        end else begin
            freeze_q <= FREEZE;
            read_q   <= READ;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            tok_q    <= freeze_q ? (vis_cnt_q != CW'(0)) : (count_q != CW'(0));

            if (wr_ok_s) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (HIT_WR && full_s && (lost_q != 8'hFF)) begin
                lost_q <= lost_q + 8'd1;
            end
            if (read_rise_s && !accept_s && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end

            // The freeze window only sees words queued before its rising edge.
            if (freeze_rise_s) begin
                vis_cnt_q <= count_q;
            end else if (accept_s) begin
                vis_cnt_q <= vis_cnt_q - CW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        shreg_q  <= mem_q[rd_ptr_q];
                        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
                        bcnt_q   <= BW'(DATA_WIDTH - 1);
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Zero fill leaves shreg_q empty once the word is out, so DATAOUT idles low.
                    shreg_q <= {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    bcnt_q  <= bcnt_q - BW'(1);
                    if (bcnt_q == BW'(0)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign HIT_FULL     = full_q;
    assign TOKOUT       = tok_q;
    assign DATAOUT      = shreg_q[DATA_WIDTH-1];
    assign LOST_CNT     = lost_q;
    assign READ_ERR_CNT = err_q;

endmodule

// File: tb/tb_monopix2_ro_emulator.sv
// Directed bench for monopix2_ro_emulator: a cycle table for the first
// transaction plus hand-written sequences for FIFO, freeze and reset corners.
module tb_monopix2_ro_emulator;

    localparam int W = 27;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         HIT_WR = 1'b0;
    logic [W-1:0] HIT_DATA = '0;
    logic         HIT_FULL;
    logic         FREEZE = 1'b0;
    logic         READ = 1'b0;
    logic         TOKOUT;
    logic         DATAOUT;
    logic [7:0]   LOST_CNT;
    logic [7:0]   READ_ERR_CNT;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         wr;
        logic [W-1:0] data;
        logic         fr;
        logic         rd;
        logic         tok;
        logic         full;
        logic         dout;
    } vec_t;

    vec_t tbl [6];

    monopix2_ro_emulator #(.DATA_WIDTH(27), .DEPTH_LOG2(4)) dut (
        .CLK(CLK), .RST(RST), .HIT_WR(HIT_WR), .HIT_DATA(HIT_DATA),
        .HIT_FULL(HIT_FULL), .FREEZE(FREEZE), .READ(READ), .TOKOUT(TOKOUT),
        .DATAOUT(DATAOUT), .LOST_CNT(LOST_CNT), .READ_ERR_CNT(READ_ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; HIT_WR = 1'b0; FREEZE = 1'b0; READ = 1'b0;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic write_word(input logic [W-1:0] w);
        HIT_WR = 1'b1; HIT_DATA = w;
        step();
        HIT_WR = 1'b0;
    endtask

    task automatic freeze_on();
        FREEZE = 1'b1;
        step();
        step();
    endtask

    // Called in the cycle after acceptance; returns after the edge that ends the shift.
    task automatic collect(output logic [W-1:0] got);
        got = '0;
        for (int i = 0; i < W; i++) begin
            got = {got[W-2:0], DATAOUT};
            step();
        end
    endtask

    task automatic read_word(input string name, input logic [W-1:0] exp);
        logic [W-1:0] got;
        READ = 1'b1;
        step();
        READ = 1'b0;
        collect(got);
        chk(name, {5'd0, got}, {5'd0, exp});
    endtask

    function automatic logic [W-1:0] wgen(input int i);
        logic [31:0] t;
        t = 32'(i) * 32'h0123457 + 32'h000000A5;
        return t[W-1:0];
    endfunction

    initial begin
        logic [W-1:0] w1;
        logic [W-1:0] got;
        logic         any;

        w1 = 27'h5A5A5A5;
        //           wr    data            fr    rd    tok   full  dout
        tbl[0] = '{1'b1, 27'h5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 27'h0000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 27'h0000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 27'h0000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 27'h0000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 27'h0000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset();
        chk("rst_full", {31'd0, HIT_FULL}, 32'd0);
        chk("rst_tok", {31'd0, TOKOUT}, 32'd0);
        chk("rst_dout", {31'd0, DATAOUT}, 32'd0);
        chk("rst_lost", {24'd0, LOST_CNT}, 32'd0);
        chk("rst_err", {24'd0, READ_ERR_CNT}, 32'd0);

        // Single word: token timing and first two bits from the table
        for (int i = 0; i < 6; i++) begin
            HIT_WR = tbl[i].wr; HIT_DATA = tbl[i].data;
            FREEZE = tbl[i].fr; READ = tbl[i].rd;
            step();
            chk($sformatf("t1_tok[%0d]", i), {31'd0, TOKOUT}, {31'd0, tbl[i].tok});
            chk($sformatf("t1_full[%0d]", i), {31'd0, HIT_FULL}, {31'd0, tbl[i].full});
            chk($sformatf("t1_dout[%0d]", i), {31'd0, DATAOUT}, {31'd0, tbl[i].dout});
        end
        got = '0;
        for (int i = 0; i < 25; i++) begin
            step();
            got = {got[W-2:0], DATAOUT};
        end
        chk("t1_bits24_0", {7'd0, got[24:0]}, {7'd0, w1[24:0]});
        step();
        chk("t1_dout_idle", {31'd0, DATAOUT}, 32'd0);
        chk("t1_err", {24'd0, READ_ERR_CNT}, 32'd0);

        // Three words in write order, then an unanswerable fourth READ
        do_reset();
        write_word(27'h4000001);
        write_word(27'h2AAAAAA);
        write_word(27'h1234567);
        freeze_on();
        read_word("t2_w0", 27'h4000001);
        chk("t2_tok_mid", {31'd0, TOKOUT}, 32'd1);
        step(); step();
        read_word("t2_w1", 27'h2AAAAAA);
        step(); step();
        read_word("t2_w2", 27'h1234567);
        chk("t2_tok_end", {31'd0, TOKOUT}, 32'd0);
        step(); step();
        READ = 1'b1;
        step();
        READ = 1'b0;
        any = DATAOUT;
        for (int i = 0; i < 28; i++) begin
            step();
            any = any | DATAOUT;
        end
        chk("t2_dout_quiet", {31'd0, any}, 32'd0);
        chk("t2_err", {24'd0, READ_ERR_CNT}, 32'd1);

        // Overflow: 20 writes into 16 slots, then a pop and write on the same full edge
        do_reset();
        HIT_WR = 1'b1;
        for (int i = 0; i < 20; i++) begin
            HIT_DATA = wgen(i);
            step();
            if (i == 14) chk("t3_full_15", {31'd0, HIT_FULL}, 32'd0);
            if (i == 15) chk("t3_full_16", {31'd0, HIT_FULL}, 32'd1);
        end
        HIT_WR = 1'b0;
        chk("t3_lost", {24'd0, LOST_CNT}, 32'd4);
        chk("t3_tok", {31'd0, TOKOUT}, 32'd1);
        freeze_on();
        READ = 1'b1; HIT_WR = 1'b1; HIT_DATA = wgen(99);
        step();
        READ = 1'b0; HIT_WR = 1'b0;
        chk("t3_lost_pop", {24'd0, LOST_CNT}, 32'd5);
        chk("t3_full_pop", {31'd0, HIT_FULL}, 32'd0);
        collect(got);
        chk("t3_head", {5'd0, got}, {5'd0, wgen(0)});

        // Word written on the freeze rise stays hidden until the next window
        do_reset();
        write_word(27'h0F0F0F0);
        write_word(27'h70F0F0F);
        FREEZE = 1'b1; HIT_WR = 1'b1; HIT_DATA = 27'h3C3C3C3;
        step();
        HIT_WR = 1'b0;
        step();
        read_word("t4_w0", 27'h0F0F0F0);
        step(); step();
        read_word("t4_w1", 27'h70F0F0F);
        chk("t4_tok_drop", {31'd0, TOKOUT}, 32'd0);
        step(); step();
        READ = 1'b1;
        step();
        READ = 1'b0;
        step(); step();
        chk("t4_err", {24'd0, READ_ERR_CNT}, 32'd1);
        chk("t4_dout_quiet", {31'd0, DATAOUT}, 32'd0);
        FREEZE = 1'b0;
        step();
        chk("t4_tok_unfrz0", {31'd0, TOKOUT}, 32'd0);
        step();
        chk("t4_tok_unfrz1", {31'd0, TOKOUT}, 32'd1);
        freeze_on();
        read_word("t4_w2", 27'h3C3C3C3);

        // READ on the freeze rise edge and READ during a shift are both rejected
        do_reset();
        write_word(27'h5555555);
        write_word(27'h6DB6DB6);
        FREEZE = 1'b1; READ = 1'b1;
        step();
        READ = 1'b0;
        step(); step();
        chk("t5_err_coinc", {24'd0, READ_ERR_CNT}, 32'd1);
        READ = 1'b1;
        step();
        READ = 1'b0;
        got = '0;
        for (int i = 0; i < W; i++) begin
            got = {got[W-2:0], DATAOUT};
            READ = (i == 4);
            step();
        end
        READ = 1'b0;
        chk("t5_w0", {5'd0, got}, {5'd0, 27'h5555555});
        chk("t5_err_shift", {24'd0, READ_ERR_CNT}, 32'd2);
        step();
        read_word("t5_w1", 27'h6DB6DB6);
        chk("t5_err_final", {24'd0, READ_ERR_CNT}, 32'd2);

        // Reset at bit 10 of a shift, then a clean transaction
        do_reset();
        write_word(27'h7000001);
        write_word(27'h1FFFFFF);
        FREEZE = 1'b1; READ = 1'b1;
        step();
        READ = 1'b0;
        step(); step();
        READ = 1'b1;
        step();
        READ = 1'b0;
        for (int i = 0; i < 16; i++) step();
        RST = 1'b1; FREEZE = 1'b0;
        step();
        chk("t6_dout", {31'd0, DATAOUT}, 32'd0);
        chk("t6_tok", {31'd0, TOKOUT}, 32'd0);
        chk("t6_full", {31'd0, HIT_FULL}, 32'd0);
        chk("t6_err", {24'd0, READ_ERR_CNT}, 32'd0);
        chk("t6_lost", {24'd0, LOST_CNT}, 32'd0);
        RST = 1'b0;
        step(); step(); step();
        chk("t6_fifo_empty", {31'd0, TOKOUT}, 32'd0);
        write_word(27'h0ABCDEF);
        step();
        chk("t6_tok_new", {31'd0, TOKOUT}, 32'd1);
        freeze_on();
        read_word("t6_fresh", 27'h0ABCDEF);
        chk("t6_tok_gone", {31'd0, TOKOUT}, 32'd0);
        chk("t6_err_end", {24'd0, READ_ERR_CNT}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/monopix2_ro_emulator.md
# monopix2_ro_emulator

Synthesizable chip-side model of the MONOPIX2 column readout. It is the transmitter counterpart of `mono_data_rx`: it answers `Freeze`/`Read` from the receiver by driving `TokOut` and a serial `DataOut` stream. Hit words are queued through a local write port. It is used for FPGA loopback and simulation benches, without silicon, and sits in the `CLK40` domain next to the core.

## Interface
- `DATA_WIDTH`, 27 — serial word length; word = {col[5:0], row[8:0], le[5:0], te[5:0]}.
- `DEPTH_LOG2`, 4 — hit FIFO depth = 2**DEPTH_LOG2 words.

Ports:
- `CLK` in 1 — single clock, 40 MHz; the same edge the receiver uses as `RX_CLK`.
- `RST` in 1 — synchronous, active-high reset.
- `HIT_WR` in 1 — write strobe for the hit FIFO.
- `HIT_DATA` in DATA_WIDTH — hit word.
- `HIT_FULL` out 1 — FIFO full.
- `FREEZE` in 1 — from receiver `RX_FREEZE`.
- `READ` in 1 — from receiver `RX_READ`.
- `TOKOUT` out 1 — token to receiver `RX_TOKEN`.
- `DATAOUT` out 1 — serial data to receiver `RX_DATA`.
- `LOST_CNT` out 8 — count of hits dropped on full FIFO; saturates at 255.
- `READ_ERR_CNT` out 8 — count of rejected READ rising edges; saturates at 255.

## Operation
- Internal registers `FREEZE_d` and `READ_d` hold the previous-cycle values. A READ rise is `READ & ~READ_d`; a FREEZE rise is `FREEZE & ~FREEZE_d`.
- FIFO `count` runs 0..2**DEPTH_LOG2.
- `HIT_WR` with `count` below full writes the word. `HIT_WR` when full drops the word and increments `LOST_CNT`. Full is evaluated on the pre-edge `count`, so a write in the same cycle as a pop while full is still dropped.
- On a FREEZE rise, `vis_cnt <= count` using the pre-edge value. A word written in the same cycle is not visible in that freeze window.
- `TOKOUT`, registered:
  - `(vis_cnt != 0)` while `FREEZE_d = 1`.
  - `(count != 0)` otherwise.
- State machine `IDLE` / `SHIFT`, with a `DATA_WIDTH`-bit shift register `shreg` and bit counter `bcnt`.
  - A READ rise is accepted when state is `IDLE`, `FREEZE_d = 1` and `vis_cnt != 0`. On acceptance:
    - pop the FIFO head into `shreg`;
    - `vis_cnt--`;
    - `bcnt <= DATA_WIDTH-1`;
    - `-> SHIFT`.
  - A READ rise that is not accepted increments `READ_ERR_CNT`. This covers: in `SHIFT`, `FREEZE_d = 0` (including a READ rise coincident with the FREEZE rise), and `vis_cnt = 0`.
  - In `SHIFT`, each edge shifts `shreg` left by one, filling with 0, and decrements `bcnt`. At `bcnt = 0` the next state is `IDLE`.
- `DATAOUT = shreg[DATA_WIDTH-1]` in `SHIFT`, else 0.
- A FREEZE fall during `SHIFT` does not abort the word; the remaining bits complete. Words left in the FIFO stay queued for the next freeze.
- Word bit order is MSB first: col[5], ..., col[0], row[8], ..., te[0].

## Timing
- Reset values: `HIT_FULL` 0, `TOKOUT` 0, `DATAOUT` 0, `LOST_CNT` 0, `READ_ERR_CNT` 0. State `IDLE`; FIFO, `vis_cnt` and `shreg` cleared. Reset applies immediately, including mid-shift.
- Token after write, unfrozen: `HIT_WR` sampled at edge N makes `count = 1` after edge N, and `TOKOUT = 1` after edge N+1.
- Read latency: a READ rise accepted at edge N puts bit MSB on `DATAOUT` in cycle N+1 (after edge N). Bit k appears in cycle N+1+(DATA_WIDTH-1-k).
- Last bit: the LSB appears in cycle N+DATA_WIDTH. The state is `IDLE` after edge N+DATA_WIDTH, so the next READ rise can be accepted at edge N+DATA_WIDTH+1 at the earliest.
- Token fall: `TOKOUT` falls in the cycle after the edge that pops the last visible word, i.e. it is registered one cycle after `vis_cnt` reaches 0.
- `HIT_FULL` is registered and reflects `count` after the edge.

## Test plan
- Load 1 word `0x5A5A5A5` (27 bits), assert FREEZE for 2 cycles, then pulse READ for 1 cycle. Required: `TOKOUT` 1 → 0 one cycle after acceptance; `DATAOUT` serializes bits 26..0 MSB first over 27 cycles starting the cycle after acceptance; `READ_ERR_CNT` = 0.
- Load 3 words, freeze, and issue 3 READ pulses each spaced 30 cycles. Required: 3 words out in write order, then `TOKOUT` = 0. A 4th READ leaves `DATAOUT` at 0 and gives `READ_ERR_CNT` = 1.
- With DEPTH_LOG2 = 4, write 20 words unfrozen. Required: `HIT_FULL` = 1 after the 16th write; `LOST_CNT` = 4.
- Freeze with 2 words queued and write 1 more while frozen; read 3 times. Required: only 2 words sent; `TOKOUT` drops after the 2nd; 3rd READ gives `READ_ERR_CNT` +1. Unfreeze → `TOKOUT` = 1 for the remaining word.
- Pulse READ again 5 cycles into a shift, and separately on the same edge as the FREEZE rise. Required: the first word completes uncorrupted and `READ_ERR_CNT` = 2.
- Assert `RST` at bit 10 of a shift. Required: all outputs 0 on the next cycle, FIFO empty, and a fresh transaction afterwards is correct.
